// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - two-master (fetch/data) to one-slave memory bus arbiter
// One outstanding transaction; responses are routed back to the master that issued the request.
module membus_arbiter #(
    parameter int XLEN              = 64,
    parameter int MEMBUS_DATA_WIDTH = 64,
    parameter int ILEN              = 32
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           ibus_valid,
    output logic                           ibus_ready,
    input  logic [XLEN-1:0]                ibus_addr,
    input  logic [ILEN-1:0]                ibus_wdata,
    input  logic [ILEN/8-1:0]              ibus_wmask,
    input  logic                           ibus_wen,
    output logic [ILEN-1:0]                ibus_rdata,
    output logic                           ibus_rvalid,

    input  logic                           dbus_valid,
    output logic                           dbus_ready,
    input  logic [XLEN-1:0]                dbus_addr,
    input  logic [MEMBUS_DATA_WIDTH-1:0]   dbus_wdata,
    input  logic [MEMBUS_DATA_WIDTH/8-1:0] dbus_wmask,
    input  logic                           dbus_wen,
    output logic [MEMBUS_DATA_WIDTH-1:0]   dbus_rdata,
    output logic                           dbus_rvalid,

    output logic                           mbus_valid,
    input  logic                           mbus_ready,
    output logic [XLEN-1:0]                mbus_addr,
    output logic [MEMBUS_DATA_WIDTH-1:0]   mbus_wdata,
    output logic [MEMBUS_DATA_WIDTH/8-1:0] mbus_wmask,
    output logic                           mbus_wen,
    input  logic [MEMBUS_DATA_WIDTH-1:0]   mbus_rdata,
    input  logic                           mbus_rvalid
);

    localparam int RATIO = MEMBUS_DATA_WIDTH / ILEN;
    localparam int SEL_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LO    = $clog2(ILEN / 8);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t                         state;
    logic                           last_d;
    logic [SEL_W-1:0]               sel;
    logic [SEL_W-1:0]               sel_next;
    logic                           contention;
    logic                           grant_d;
    logic                           grant_i;
    logic                           idle;
    logic                           accept;
    logic [MEMBUS_DATA_WIDTH-1:0]   ibus_wdata_ext;

    // Fetch is read-only, so its write controls are deliberately dropped.
    logic unused_ibus_write;
    assign unused_ibus_write = ^{ibus_wen, ibus_wmask};

    always_comb begin
        contention = ibus_valid && dbus_valid;
        grant_d    = dbus_valid && !(contention && last_d);
        grant_i    = ibus_valid && !grant_d;
        idle       = (state == IDLE) && rst;

        ibus_wdata_ext              = '0;
        ibus_wdata_ext[ILEN-1:0]    = ibus_wdata;
        sel_next = (RATIO > 1) ? ibus_addr[LO +: SEL_W] : '0;

        mbus_valid = idle && (grant_d || grant_i);
        mbus_addr  = grant_d ? dbus_addr : ibus_addr;
        mbus_wdata = grant_d ? dbus_wdata : ibus_wdata_ext;
        mbus_wmask = grant_d ? dbus_wmask : '0;
        mbus_wen   = grant_d && dbus_wen;
        accept     = mbus_valid && mbus_ready;

        ibus_ready = idle && grant_i && mbus_ready;
        dbus_ready = idle && grant_d && mbus_ready;

        // A response seen in IDLE (including one left over from a reset) has no owner.
        ibus_rvalid = rst && (state == WAIT_I) && mbus_rvalid;
        dbus_rvalid = rst && (state == WAIT_D) && mbus_rvalid;
        ibus_rdata  = mbus_rdata[sel*ILEN +: ILEN];
        dbus_rdata  = mbus_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
            sel    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= grant_d ? WAIT_D : WAIT_I;
                        if (contention) last_d <= grant_d;
                        if (grant_i)    sel    <= sel_next;
                    end
                end
                WAIT_I, WAIT_D: begin
                    if (mbus_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - self-checking bench for membus_arbiter
// Ownership-level reference model, memory responder and directed scenarios.
module tb_membus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_valid, ibus_ready, ibus_wen, ibus_rvalid;
    logic [63:0] ibus_addr;
    logic [31:0] ibus_wdata, ibus_rdata;
    logic [3:0]  ibus_wmask;
    logic        dbus_valid, dbus_ready, dbus_wen, dbus_rvalid;
    logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [7:0]  dbus_wmask;
    logic        mbus_valid, mbus_ready, mbus_wen, mbus_rvalid;
    logic [63:0] mbus_addr, mbus_wdata, mbus_rdata;
    logic [7:0]  mbus_wmask;

    int total = 0;
    int bad   = 0;

    membus_arbiter dut (
        .clk(clk), .rst(rst),
        .ibus_valid(ibus_valid), .ibus_ready(ibus_ready), .ibus_addr(ibus_addr),
        .ibus_wdata(ibus_wdata), .ibus_wmask(ibus_wmask), .ibus_wen(ibus_wen),
        .ibus_rdata(ibus_rdata), .ibus_rvalid(ibus_rvalid),
        .dbus_valid(dbus_valid), .dbus_ready(dbus_ready), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wmask(dbus_wmask), .dbus_wen(dbus_wen),
        .dbus_rdata(dbus_rdata), .dbus_rvalid(dbus_rvalid),
        .mbus_valid(mbus_valid), .mbus_ready(mbus_ready), .mbus_addr(mbus_addr),
        .mbus_wdata(mbus_wdata), .mbus_wmask(mbus_wmask), .mbus_wen(mbus_wen),
        .mbus_rdata(mbus_rdata), .mbus_rvalid(mbus_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Which master the rules select in IDLE: 0 none, 1 fetch, 2 data.
    function automatic int pick(input bit iv, input bit dv, input bit ld);
        if (iv && dv) return ld ? 1 : 2;
        if (dv) return 2;
        if (iv) return 1;
        return 0;
    endfunction

    // Reference model: who owns the outstanding transaction, round-robin flag, fetch half.
    int  owner = 0;
    bit  m_last_d = 0;
    int  m_sel = 0;
    int  cyc = 0;
    byte m_log[$];
    int  m_cyc[$];

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst) begin
            owner    = 0;
            m_last_d = 0;
        end else if (owner == 0) begin
            int g;
            g = pick(ibus_valid, dbus_valid, m_last_d);
            if (g != 0 && mbus_ready) begin
                m_log.push_back(g == 2 ? "D" : "I");
                m_cyc.push_back(cyc);
                if (ibus_valid && dbus_valid) m_last_d = (g == 2);
                if (g == 1) m_sel = int'(ibus_addr % 64'd8) / 4;
                owner = g;
            end
        end else if (mbus_rvalid) begin
            owner = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("rst_mbus_valid", mbus_valid, 0);
            chk("rst_ibus_ready", ibus_ready, 0);
            chk("rst_dbus_ready", dbus_ready, 0);
            chk("rst_ibus_rvalid", ibus_rvalid, 0);
            chk("rst_dbus_rvalid", dbus_rvalid, 0);
        end else begin
            int g;
            g = (owner == 0) ? pick(ibus_valid, dbus_valid, m_last_d) : 0;
            chk("mbus_valid", mbus_valid, g != 0);
            chk("ibus_ready", ibus_ready, g == 1 && mbus_ready);
            chk("dbus_ready", dbus_ready, g == 2 && mbus_ready);
            chk("ibus_rvalid", ibus_rvalid, owner == 1 && mbus_rvalid);
            chk("dbus_rvalid", dbus_rvalid, owner == 2 && mbus_rvalid);
            if (g == 2) begin
                chk("mbus_addr_d", mbus_addr, dbus_addr);
                chk("mbus_wdata_d", mbus_wdata, dbus_wdata);
                chk("mbus_wmask_d", mbus_wmask, dbus_wmask);
                chk("mbus_wen_d", mbus_wen, dbus_wen);
            end
            if (g == 1) begin
                chk("mbus_addr_i", mbus_addr, ibus_addr);
                chk("mbus_wmask_i", mbus_wmask, 0);
                chk("mbus_wen_i", mbus_wen, 0);
            end
            if (owner == 1 && mbus_rvalid)
                chk("ibus_rdata", ibus_rdata, (mbus_rdata >> (32 * m_sel)) & 64'hFFFF_FFFF);
        end
        chk("dbus_rdata", dbus_rdata, mbus_rdata);
    end

    // Observed DUT handshakes, recorded half a cycle before the accepting edge.
    byte dut_log[$];
    int  dut_cyc[$];
    initial forever begin
        @(negedge clk);
        if (rst && dbus_valid && dbus_ready) begin dut_log.push_back("D"); dut_cyc.push_back(cyc); end
        if (rst && ibus_valid && ibus_ready) begin dut_log.push_back("I"); dut_cyc.push_back(cyc); end
    end

    // Memory: answers each accepted request lat cycles later.
    int          lat = 1;
    int          cnt = 0;
    logic [63:0] resp_data = '0;
    initial begin
        bit hit;
        mbus_rvalid = 1'b0;
        mbus_rdata  = '0;
        forever begin
            @(negedge clk);
            hit = mbus_valid && mbus_ready;
            @(posedge clk);
            #1;
            if (hit) cnt = lat;
            if (cnt == 1) begin
                mbus_rvalid = 1'b1;
                mbus_rdata  = resp_data;
            end else begin
                mbus_rvalid = 1'b0;
            end
            if (cnt > 0) cnt--;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output bit gi, output bit gd);
        gi = 0;
        gd = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ibus_rvalid || dbus_rvalid) begin
                gi = ibus_rvalid;
                gd = dbus_rvalid;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL resp_timeout actual=none expected=rvalid within 10 cycles");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit    gi, gd;
        int    rv_seen;
        string exp_order;
        rst = 0;
        ibus_valid = 0; ibus_addr = '0; ibus_wdata = '0; ibus_wmask = '0; ibus_wen = 0;
        dbus_valid = 1; dbus_addr = 64'h8000_0010; dbus_wdata = '0; dbus_wmask = '0; dbus_wen = 0;
        mbus_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mbus_valid_lit", mbus_valid, 0);
        chk("reset_dbus_ready_lit", dbus_ready, 0);
        dbus_valid = 0;
        step();
        rst = 1;
        step();

        // Data read
        dbus_addr = 64'h8000_0010; dbus_valid = 1; resp_data = 64'h1122_3344_5566_7788;
        step();
        dbus_valid = 0;
        wait_resp(gi, gd);
        chk("t1_dbus_rvalid", gd, 1);
        chk("t1_ibus_rvalid", gi, 0);
        chk("t1_dbus_rdata", dbus_rdata, 64'h1122_3344_5566_7788);
        step();

        // Fetch, upper and lower halves
        ibus_addr = 64'h8000_0004; ibus_valid = 1; resp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        ibus_valid = 0;
        wait_resp(gi, gd);
        chk("t2_ibus_rvalid", gi, 1);
        chk("t2_ibus_rdata_hi", ibus_rdata, 32'hAAAA_BBBB);
        step();
        ibus_addr = 64'h8000_0000; ibus_valid = 1;
        step();
        ibus_valid = 0;
        wait_resp(gi, gd);
        chk("t2_ibus_rdata_lo", ibus_rdata, 32'hCCCC_DDDD);
        step();

        // Fetch with write controls set
        ibus_addr = 64'h8000_0008; ibus_wen = 1; ibus_wmask = 4'hF; ibus_valid = 1;
        resp_data = 64'h0000_1111_2222_3333;
        @(negedge clk);
        chk("t3_mbus_valid", mbus_valid, 1);
        chk("t3_mbus_wen", mbus_wen, 0);
        chk("t3_mbus_wmask", mbus_wmask, 0);
        step();
        ibus_valid = 0; ibus_wen = 0; ibus_wmask = 0;
        wait_resp(gi, gd);
        chk("t3_ibus_rvalid", gi, 1);
        chk("t3_ibus_rdata", ibus_rdata, 32'h2222_3333);
        step();

        // Data write
        dbus_addr = 64'h8000_0020; dbus_wdata = 64'hDEAD_BEEF; dbus_wmask = 8'h0F; dbus_wen = 1;
        dbus_valid = 1;
        @(negedge clk);
        chk("t4_mbus_wen", mbus_wen, 1);
        chk("t4_mbus_wmask", mbus_wmask, 8'h0F);
        chk("t4_mbus_wdata", mbus_wdata, 64'hDEAD_BEEF);
        chk("t4_mbus_addr", mbus_addr, 64'h8000_0020);
        step();
        dbus_valid = 0; dbus_wen = 0; dbus_wmask = 0;
        wait_resp(gi, gd);
        chk("t4_dbus_rvalid", gd, 1);
        step();

        // Memory stalls, fetch withdraws its request
        mbus_ready = 0; ibus_valid = 1;
        @(negedge clk);
        chk("t5_ibus_ready_stall", ibus_ready, 0);
        step();
        ibus_valid = 0; mbus_ready = 1;
        step();
        step();

        // Contention from reset
        rst = 0;
        step();
        step();
        rst = 1;
        dut_log.delete(); dut_cyc.delete(); m_log.delete(); m_cyc.delete();
        ibus_addr = 64'h8000_0004; dbus_addr = 64'h8000_0010;
        ibus_valid = 1; dbus_valid = 1;
        repeat (8) step();
        ibus_valid = 0; dbus_valid = 0;
        step();
        exp_order = "DIDI";
        chk("t6_dut_count", dut_log.size(), 4);
        chk("t6_model_count", m_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_dut_grant%0d", i), (i < dut_log.size()) ? dut_log[i] : 8'h0, exp_order[i]);
            chk($sformatf("t6_model_grant%0d", i), (i < m_log.size()) ? m_log[i] : 8'h0, exp_order[i]);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_dut_spacing%0d", i),
                (i + 1 < dut_cyc.size()) ? dut_cyc[i+1] - dut_cyc[i] : 0, 2);
            chk($sformatf("t6_model_spacing%0d", i),
                (i + 1 < m_cyc.size()) ? m_cyc[i+1] - m_cyc[i] : 0, 2);
        end

        // Reset while waiting on a data response; the late response is spurious
        lat = 4;
        dbus_addr = 64'h8000_0030; dbus_valid = 1; resp_data = 64'hFFFF_0000_FFFF_0000;
        step();
        dbus_valid = 0; rst = 0;
        step();
        step();
        rst = 1;
        lat = 1;
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ibus_rvalid || dbus_rvalid) rv_seen++;
            step();
        end
        chk("t7_no_rvalid_after_reset", rv_seen, 0);
        ibus_addr = 64'h8000_0004; ibus_valid = 1; resp_data = 64'h0123_4567_89AB_CDEF;
        step();
        ibus_valid = 0;
        wait_resp(gi, gd);
        chk("t7_ibus_rvalid", gi, 1);
        chk("t7_dbus_rvalid", gd, 0);
        chk("t7_ibus_rdata", ibus_rdata, 32'h0123_4567);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
